// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds bus width, rw command encodings and the FSM state enum.
package mem_arbiter_pkg;

  localparam int COMMON_WIDTH = 32;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_READ  = 2'd1;
  localparam logic [1:0] RW_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // rw = 3 is reserved and never counts as a request.
  function automatic logic rw_valid(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// Ports: rq_rw/addr/wdata/mask in, rq_busy/done/rdata/err out,
//        mem_rw/addr/wdata/mask out, mem_ready/mem_rdata in.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [1:0][1:0]              rq_rw;
  logic [1:0][COMMON_WIDTH-1:0] rq_addr;
  logic [1:0][COMMON_WIDTH-1:0] rq_wdata;
  logic [1:0][3:0]              rq_mask;
  logic [1:0]                   rq_busy;
  logic [1:0]                   rq_done;
  logic [COMMON_WIDTH-1:0]      rq_rdata;
  logic                         rq_err;

  logic [1:0]                   mem_rw;
  logic [COMMON_WIDTH-1:0]      mem_addr;
  logic [COMMON_WIDTH-1:0]      mem_wdata;
  logic [3:0]                   mem_mask;
  logic                         mem_ready;
  logic [COMMON_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  rq_rw, rq_addr, rq_wdata, rq_mask,
    output rq_busy, rq_done, rq_rdata, rq_err,
    output mem_rw, mem_addr, mem_wdata, mem_mask,
    input  mem_ready, mem_rdata
  );

  modport master (
    output rq_rw, rq_addr, rq_wdata, rq_mask,
    input  rq_busy, rq_done, rq_rdata, rq_err,
    input  mem_rw, mem_addr, mem_wdata, mem_mask,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant register.
// Ports: req_i pending mask, en_i commit grant, vld_o any grant, idx_o winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       vld_o,
  output logic       idx_o
);

  logic last_q;
  logic last_d;

  // Contention goes to the port not granted last; otherwise the sole requester.
  always_comb begin
    vld_o = |req_i;
    idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
    last_d = last_q;
    if (en_i && vld_o) begin
      last_d = idx_o;
    end
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (data/instruction) arbiter onto one memory command bus.
// Ports: clk, rst (async high), bus (slave view of mem_arbiter_if).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  state_e                  state_q, state_d;
  logic                    idx_q, idx_d;
  logic [1:0]              rw_q, rw_d;
  logic [COMMON_WIDTH-1:0] addr_q, addr_d;
  logic [COMMON_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]              mask_q, mask_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [COMMON_WIDTH-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [1:0] pend;
  logic       gnt_vld;
  logic       gnt_idx;

  assign pend[0] = rw_valid(bus.rq_rw[0]);
  assign pend[1] = rw_valid(bus.rq_rw[1]);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (pend),
    .en_i  (state_q == S_IDLE),
    .vld_o (gnt_vld),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_ACTIVE;
          idx_d   = gnt_idx;
          rw_d    = bus.rq_rw[gnt_idx];
          addr_d  = bus.rq_addr[gnt_idx];
          wdata_d = bus.rq_wdata[gnt_idx];
          mask_d  = bus.rq_mask[gnt_idx];
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_q + 1'b1;
        // mem_ready wins over a timeout hit in the same cycle.
        if (bus.mem_ready) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (rw_q == RW_READ) begin
            rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == TO_CNT) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 1'b0;
      rw_q    <= RW_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_rw    = (state_q == S_ACTIVE) ? rw_q : RW_NONE;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mask  = mask_q;

  assign bus.rq_busy  = (state_q != S_IDLE) ? (2'b01 << idx_q) : 2'b00;
  assign bus.rq_done  = (state_q == S_DONE) ? (2'b01 << idx_q) : 2'b00;
  assign bus.rq_err   = (state_q == S_DONE) && err_q;
  assign bus.rq_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a transaction-level model.
// Directed scenarios followed by randomized request/latency rounds.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          m_last;
  logic [31:0] m_rdata;

  logic [1:0]  t_rw    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_mask  [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bus.rq_rw[i]    = t_rw[i];
      bus.rq_addr[i]  = t_addr[i];
      bus.rq_wdata[i] = t_wdata[i];
      bus.rq_mask[i]  = t_mask[i];
    end
  endtask

  function automatic bit pend(input logic [1:0] rw);
    return (rw == 2'd1) || (rw == 2'd2);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  bus.rq_busy,   2'b00);
    chk({tag, "_done"},  bus.rq_done,   2'b00);
    chk({tag, "_err"},   bus.rq_err,    1'b0);
    chk({tag, "_rdata"}, bus.rq_rdata,  32'h0);
    chk({tag, "_mrw"},   bus.mem_rw,    2'd0);
    chk({tag, "_maddr"}, bus.mem_addr,  32'h0);
    chk({tag, "_mwd"},   bus.mem_wdata, 32'h0);
    chk({tag, "_mmask"}, bus.mem_mask,  4'h0);
  endtask

  // One arbitration round from IDLE. lat = edge after grant carrying
  // mem_ready (0 = never). Ends in the IDLE cycle after DONE.
  task automatic serve(input int lat, input bit scramble,
                       input bit use_fix, input logic [31:0] fix_rd);
    int          w;
    logic [1:0]  rw;
    logic [31:0] a, wd, rd;
    logic [3:0]  mk;
    logic [1:0]  oh;
    bit          err, fin;
    drive();
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    if (!pend(t_rw[0]) && !pend(t_rw[1])) begin
      step();
      chk("nogrant_busy", bus.rq_busy, 2'b00);
      chk("nogrant_mrw",  bus.mem_rw,  2'd0);
      bus.mem_ready = 1'b0;
      return;
    end
    if (pend(t_rw[0]) && pend(t_rw[1])) w = 1 - m_last;
    else w = pend(t_rw[0]) ? 0 : 1;
    m_last = w;
    oh = (w == 0) ? 2'b01 : 2'b10;
    rw = t_rw[w]; a = t_addr[w]; wd = t_wdata[w]; mk = t_mask[w];
    step();
    chk("grant_busy", bus.rq_busy,   oh);
    chk("grant_mrw",  bus.mem_rw,    rw);
    chk("grant_addr", bus.mem_addr,  a);
    chk("grant_wd",   bus.mem_wdata, wd);
    chk("grant_mask", bus.mem_mask,  mk);
    if (scramble) begin
      t_addr[w]  = ~a;
      t_wdata[w] = $urandom;
      t_mask[w]  = ~mk;
      drive();
    end
    fin = 0;
    err = 0;
    for (int k = 1; k <= TO + 1 && !fin; k++) begin
      rd = use_fix ? fix_rd : $urandom;
      bus.mem_ready = (k == lat);
      bus.mem_rdata = rd;
      step();
      if (k == lat) begin
        fin = 1; err = 0;
        if (rw == 2'd1) m_rdata = rd;
      end else if (k == TO + 1) begin
        fin = 1; err = 1; m_rdata = 32'h0;
      end
      if (fin) begin
        chk("done_pulse", bus.rq_done,  oh);
        chk("done_err",   bus.rq_err,   err);
        chk("done_rdata", bus.rq_rdata, m_rdata);
        chk("done_busy",  bus.rq_busy,  oh);
        chk("done_mrw",   bus.mem_rw,   2'd0);
      end else begin
        chk("act_done", bus.rq_done,   2'b00);
        chk("act_mrw",  bus.mem_rw,    rw);
        chk("act_addr", bus.mem_addr,  a);
        chk("act_wd",   bus.mem_wdata, wd);
      end
    end
    t_rw[w] = 2'd0;
    drive();
    bus.mem_ready = 1'($urandom);
    step();
    chk("bub_busy",  bus.rq_busy,  2'b00);
    chk("bub_done",  bus.rq_done,  2'b00);
    chk("bub_err",   bus.rq_err,   1'b0);
    chk("bub_mrw",   bus.mem_rw,   2'd0);
    chk("bub_rdata", bus.rq_rdata, m_rdata);
    bus.mem_ready = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [1:0] rw,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] mk);
    t_rw[p] = rw; t_addr[p] = a; t_wdata[p] = wd; t_mask[p] = mk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) set_req(i, 2'd0, 32'h0, 32'h0, 4'h0);
    drive();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    m_last  = 1;
    m_rdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // rw = 3 is never a request
    set_req(0, 2'd3, 32'h40, 32'h1, 4'hF);
    for (int j = 0; j < 3; j++) serve(1, 0, 0, 32'h0);
    t_rw[0] = 2'd0;

    // read with 3-cycle latency
    set_req(0, 2'd1, 32'h100, 32'h0, 4'h0);
    serve(3, 0, 1, 32'hDEADBEEF);
    chk("rd_deadbeef", bus.rq_rdata, 32'hDEADBEEF);

    // reset while ACTIVE, then stray mem_ready
    set_req(0, 2'd1, 32'h200, 32'h0, 4'h0);
    drive();
    step();
    step();
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    t_rw[0] = 2'd0;
    drive();
    step();
    rst = 1'b0;
    m_last  = 1;
    m_rdata = 32'h0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h12345678;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("stray_done",  bus.rq_done,  2'b00);
      chk("stray_err",   bus.rq_err,   1'b0);
      chk("stray_rdata", bus.rq_rdata, 32'h0);
      chk("stray_mrw",   bus.mem_rw,   2'd0);
    end
    bus.mem_ready = 1'b0;

    // simultaneous writes: round-robin from port 0
    for (int r = 0; r < 2; r++) begin
      set_req(0, 2'd2, 32'h1000 + r, 32'hA0A0_0000 + r, 4'hF);
      set_req(1, 2'd2, 32'h2000 + r, 32'hB0B0_0000 + r, 4'h3);
      serve(2, 0, 0, 32'h0);
      serve(1, 0, 0, 32'h0);
    end

    // masked write with mid-flight address change
    set_req(0, 2'd2, 32'h300, 32'h00ABCD00, 4'b0110);
    serve(5, 1, 0, 32'h0);

    // timeout on port 1
    set_req(1, 2'd1, 32'h400, 32'h0, 4'h0);
    serve(0, 0, 0, 32'h0);

    // mem_ready exactly on the timeout cycle, then earliest completion
    set_req(0, 2'd1, 32'h500, 32'h0, 4'h0);
    serve(TO + 1, 0, 1, 32'hCAFE0001);
    set_req(1, 2'd1, 32'h600, 32'h0, 4'h0);
    serve(1, 0, 1, 32'hCAFE0002);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom,
                4'($urandom));
      end
      for (int j = 0; j < 3; j++) begin
        serve($urandom_range(0, TO + 1), 1'($urandom), 0, 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
